// File: rtl/router_pkg.sv
// -----------------------------------------------------------------------------
// router_pkg
// Shared definitions for the 1x3 router: byte width, output FIFO geometry,
// header byte field positions and the synchronizer soft-reset time-out.
// Header byte layout: [7:2] payload length, [1:0] destination address.
// -----------------------------------------------------------------------------
package router_pkg;

    localparam int DATA_W       = 8;
    localparam int ROUTER_DEPTH = 16;
    localparam int PTR_W        = 4;

    // Header byte field positions
    localparam int LEN_MSB  = 7;
    localparam int LEN_LSB  = 2;
    localparam int ADDR_MSB = 1;
    localparam int ADDR_LSB = 0;

    // Read-side packet byte counter width; holds payload length + 1 (max 64)
    localparam int PKT_CNT_W = 7;

    // Cycles an output port may sit unread before the synchronizer flushes it
    localparam int SOFT_RESET_TIMEOUT = 30;

    // One stored FIFO entry: header flag alongside the byte
    typedef struct packed {
        logic              hdr;
        logic [DATA_W-1:0] data;
    } fifo_entry_t;

    // Bytes still to come after a header: payload plus the parity byte
    function automatic logic [PKT_CNT_W-1:0] hdr_remaining(input logic [DATA_W-1:0] hdr_byte);
        return PKT_CNT_W'(hdr_byte[LEN_MSB:LEN_LSB]) + PKT_CNT_W'(1);
    endfunction

endpackage

// File: rtl/router_fifo_if.sv
// -----------------------------------------------------------------------------
// router_fifo_if
// Bundles the write side (from the synchronizer / router core), the read side
// (external reader) and the status flags of one router output FIFO.
//   master : drives soft_reset, wr_en, lfd_state, din, rd_en;
//            observes dout, full, empty
//   slave  : the FIFO itself (mirror of master)
// -----------------------------------------------------------------------------
interface router_fifo_if #(
    parameter int DATA_W = router_pkg::DATA_W
);
    logic              soft_reset;
    logic              wr_en;
    logic              lfd_state;
    logic [DATA_W-1:0] din;
    logic              rd_en;
    logic [DATA_W-1:0] dout;
    logic              full;
    logic              empty;

    modport master (
        output soft_reset, wr_en, lfd_state, din, rd_en,
        input  dout, full, empty
    );

    modport slave (
        input  soft_reset, wr_en, lfd_state, din, rd_en,
        output dout, full, empty
    );
endinterface

// File: rtl/router_fifo_mem.sv
// -----------------------------------------------------------------------------
// router_fifo_mem
// Simple dual-port register array: synchronous write, asynchronous read.
// Contents are not reset; the owning FIFO's pointers decide what is valid.
//   clk   : clock, rising edge
//   we    : write enable
//   waddr : write index
//   wdata : write entry
//   raddr : read index
//   rdata : entry at raddr (combinational)
// -----------------------------------------------------------------------------
module router_fifo_mem #(
    parameter int DEPTH = 16,
    parameter int PTR_W = 4,
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [PTR_W-1:0] raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/router_fifo.sv
// -----------------------------------------------------------------------------
// router_fifo
// Per-port output FIFO of the 1x3 router. Stores {hdr_flag, byte} entries,
// reports full/empty to the synchronizer and supplies registered bytes to the
// external reader. On the read side it counts the bytes of the current packet
// so that dout returns to 0 once the parity byte has been delivered.
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : router_fifo_if.slave (soft_reset, wr_en, lfd_state, din, rd_en in;
//          dout, full, empty out)
// -----------------------------------------------------------------------------
module router_fifo #(
    parameter int DATA_W = router_pkg::DATA_W,
    parameter int DEPTH  = router_pkg::ROUTER_DEPTH,
    parameter int PTR_W  = router_pkg::PTR_W
) (
    input  logic          clk,
    input  logic          rst,
    router_fifo_if.slave  bus
);
    import router_pkg::*;

    localparam logic [PTR_W:0] PTR_ONE = (PTR_W+1)'(1);

    logic [PTR_W:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]      rd_ptr_q, rd_ptr_d;
    logic [PKT_CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
    logic [DATA_W-1:0]   dout_q, dout_d;

    logic full;
    logic empty;
    logic wr_acc;
    logic rd_acc;
    logic mem_we;
    logic [DATA_W:0] rd_entry;

    // Extra wrap bit distinguishes full from empty when the indices match
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

    // full alone decides write acceptance; a same-cycle read does not free a slot
    assign wr_acc = bus.wr_en && !full;
    assign rd_acc = bus.rd_en && !empty;
    assign mem_we = wr_acc && !bus.soft_reset;

    router_fifo_mem #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W),
        .WIDTH (DATA_W + 1)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wr_ptr_q[PTR_W-1:0]),
        .wdata ({bus.lfd_state, bus.din}),
        .raddr (rd_ptr_q[PTR_W-1:0]),
        .rdata (rd_entry)
    );

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        pkt_cnt_d = pkt_cnt_q;
        dout_d    = dout_q;

        if (bus.soft_reset) begin
            // Flush: all packet state is dropped along with any same-cycle access
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            pkt_cnt_d = '0;
            dout_d    = '0;
        end else begin
            if (wr_acc) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end

            if (rd_acc) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
                dout_d   = rd_entry[DATA_W-1:0];
                if (rd_entry[DATA_W]) begin
                    pkt_cnt_d = hdr_remaining(rd_entry[DATA_W-1:0]);
                end else if (pkt_cnt_q != '0) begin
                    // Stray bytes outside a packet leave the count at zero
                    pkt_cnt_d = pkt_cnt_q - PKT_CNT_W'(1);
                end
            end else if (pkt_cnt_q == '0) begin
                // Packet fully delivered (or none open): idle the output bus
                dout_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            pkt_cnt_q <= '0;
            dout_q    <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            pkt_cnt_q <= pkt_cnt_d;
            dout_q    <= dout_d;
        end
    end

    assign bus.dout  = dout_q;
    assign bus.full  = full;
    assign bus.empty = empty;

endmodule

// File: tb/tb_router_fifo.sv
// -----------------------------------------------------------------------------
// tb_router_fifo
// Self-checking bench for router_fifo. Accepted writes push {hdr, byte} onto a
// scoreboard queue; accepted reads pop the expected byte, which is compared
// against dout one cycle later. full/empty/dout are checked every cycle.
// -----------------------------------------------------------------------------
module tb_router_fifo;
    import router_pkg::*;

    logic clk;
    logic rst;

    router_fifo_if #(.DATA_W(DATA_W)) bus ();

    router_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (ROUTER_DEPTH),
        .PTR_W  (PTR_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DATA_W:0] sb_q[$];
    int              exp_pkt  = 0;
    logic [7:0]      exp_dout = 8'h00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, advance the reference, sample after the edge
    task automatic cycle(input bit wr, input bit lfd, input logic [7:0] d,
                         input bit rd, input bit sr);
        bit              rd_acc;
        bit              wr_acc;
        logic [DATA_W:0] e;
        bus.wr_en      = wr;
        bus.lfd_state  = lfd;
        bus.din        = d;
        bus.rd_en      = rd;
        bus.soft_reset = sr;
        rd_acc = 1'b0;
        if (sr) begin
            sb_q.delete();
            exp_pkt  = 0;
            exp_dout = 8'h00;
        end else begin
            rd_acc = rd && (sb_q.size() > 0);
            wr_acc = wr && (sb_q.size() < ROUTER_DEPTH);
            if (rd_acc) begin
                e = sb_q.pop_front();
                exp_dout = e[7:0];
                if (e[8])             exp_pkt = int'(e[7:2]) + 1;
                else if (exp_pkt > 0) exp_pkt = exp_pkt - 1;
            end else if (exp_pkt == 0) begin
                exp_dout = 8'h00;
            end
            if (wr_acc) sb_q.push_back({lfd, d});
        end
        @(posedge clk);
        #1;
        if (rd_acc) $display("read: dout=%02h expected=%02h", bus.dout, exp_dout);
        check("dout",  {24'd0, bus.dout},  {24'd0, exp_dout});
        check("full",  {31'd0, bus.full},  {31'd0, sb_q.size() == ROUTER_DEPTH});
        check("empty", {31'd0, bus.empty}, {31'd0, sb_q.size() == 0});
        bus.wr_en      = 1'b0;
        bus.lfd_state  = 1'b0;
        bus.rd_en      = 1'b0;
        bus.soft_reset = 1'b0;
    endtask

    task automatic wr_byte(input bit lfd, input logic [7:0] d);
        cycle(1'b1, lfd, d, 1'b0, 1'b0);
    endtask

    task automatic rd_byte();
        cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic drain();
        while (sb_q.size() > 0) rd_byte();
        idle();
    endtask

    initial begin
        logic [7:0] par;
        bus.wr_en = 1'b0; bus.lfd_state = 1'b0; bus.din = 8'h00;
        bus.rd_en = 1'b0; bus.soft_reset = 1'b0;
        rst = 1'b1;
        #1 rst = 1'b0;
        #2;
        check("rst_empty", {31'd0, bus.empty}, 32'd1);
        check("rst_full",  {31'd0, bus.full},  32'd0);
        check("rst_dout",  {24'd0, bus.dout},  32'd0);
        #19 rst = 1'b1;
        @(posedge clk); #1;

        // Header 0x0D (len 3, addr 1), three payload bytes, parity
        par = 8'h0D ^ 8'h11 ^ 8'h22 ^ 8'h33;
        wr_byte(1'b1, 8'h0D);
        wr_byte(1'b0, 8'h11);
        wr_byte(1'b0, 8'h22);
        wr_byte(1'b0, 8'h33);
        wr_byte(1'b0, par);
        for (int i = 0; i < 5; i++) rd_byte();
        idle();
        idle();

        // Fill to 16, 17th write rejected, drain in order
        for (int i = 0; i < 16; i++) wr_byte(1'b0, 8'hA0 + 8'(i));
        wr_byte(1'b0, 8'hFF);
        drain();

        // Full FIFO with simultaneous write and read: only the read happens
        for (int i = 0; i < 16; i++) wr_byte(1'b0, 8'hC0 + 8'(i));
        cycle(1'b1, 1'b0, 8'hEE, 1'b1, 1'b0);
        drain();

        // Half full, 20 cycles of simultaneous read/write across the wrap
        for (int i = 0; i < 8; i++) wr_byte(1'b0, 8'h40 + 8'(i));
        for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0, 8'h60 + 8'(i), 1'b1, 1'b0);
        drain();

        // soft_reset during 3rd payload read with a concurrent write
        wr_byte(1'b1, 8'h0C);
        wr_byte(1'b0, 8'h71);
        wr_byte(1'b0, 8'h72);
        wr_byte(1'b0, 8'h73);
        wr_byte(1'b0, 8'h7F);
        rd_byte();
        rd_byte();
        rd_byte();
        cycle(1'b1, 1'b0, 8'h99, 1'b1, 1'b1);
        idle();
        // Stray byte after the flush: shown once, then bus idles (count is zero)
        wr_byte(1'b0, 8'h55);
        rd_byte();
        idle();

        // Asynchronous reset mid-packet
        wr_byte(1'b1, 8'h08);
        wr_byte(1'b0, 8'h81);
        wr_byte(1'b0, 8'h82);
        rd_byte();
        #3 rst = 1'b0;
        #1;
        check("arst_empty", {31'd0, bus.empty}, 32'd1);
        check("arst_full",  {31'd0, bus.full},  32'd0);
        check("arst_dout",  {24'd0, bus.dout},  32'd0);
        sb_q.delete();
        exp_pkt  = 0;
        exp_dout = 8'h00;
        @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk); #1;
        rd_byte();
        wr_byte(1'b0, 8'h91);
        wr_byte(1'b0, 8'h92);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/router_fifo.md
Name: router_fifo

Overview:
- Per-port output FIFO of the 1x3 router; three instances sit directly downstream of the synchronizer.
- Consumes one bit of the synchronizer's wr_en[2:0] and the matching soft_reset_N.
- Returns full_N/empty_N to the synchronizer and supplies bytes to the external reader.
- Tags each stored byte with a header flag, and tracks packet length on the read side so dout returns to 0 after a packet's final (parity) byte.

Parameters:
- DATA_W, 8, width of one router byte.
- DEPTH, 16, number of entries; power of two.
- PTR_W, 4, log2(DEPTH); pointers are PTR_W+1 bits wide (extra wrap bit).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- soft_reset  in  1  synchronous flush from synchronizer (time-out on unread port).
- wr_en  in  1  write request, one bit of synchronizer wr_en.
- lfd_state  in  1  high with wr_en when din is the packet header byte.
- din  in  DATA_W  write data; header byte layout: [7:2] payload length, [1:0] destination address.
- rd_en  in  1  read request from external reader.
- dout  out  DATA_W  registered read data.
- full  out  1  no free entries.
- empty  out  1  no stored entries.

Behaviour:
- Storage: DEPTH entries, each DATA_W+1 bits: {hdr_flag, byte}. hdr_flag is written from lfd_state.
- Priority: rst (async) > soft_reset > normal operation.
- rst low, asynchronous: wr_ptr=0, rd_ptr=0, pkt_cnt=0, dout=0, full=0, empty=1. Memory contents are don't-care.
- soft_reset high at an edge has the same effect as rst (pointers, pkt_cnt, dout cleared). Any wr_en or rd_en in that cycle is dropped.
- Write accepted iff wr_en && !full. The entry at wr_ptr[PTR_W-1:0] is written and wr_ptr increments.
- Read accepted iff rd_en && !empty. dout <= entry at rd_ptr on that edge (1-cycle latency) and rd_ptr increments.
- Simultaneous accepted write and read: both happen; occupancy unchanged.
- When full, a write is rejected even if rd_en is high that cycle.
- Status flags, combinational from the registered pointers:
  - empty = (wr_ptr == rd_ptr).
  - full = (MSBs differ and lower PTR_W bits equal).
- Pointer wrap: natural modulo 2^(PTR_W+1). No special case at index DEPTH-1 -> 0.
- pkt_cnt, 7 bits:
  - Accepted read of a hdr_flag=1 entry: pkt_cnt <= byte[7:2] + 1 (payload plus parity).
  - Accepted read of a hdr_flag=0 entry: pkt_cnt <= pkt_cnt - 1, saturating at 0.
- dout clear: in a cycle with no accepted read, if pkt_cnt == 0, dout <= 0; otherwise dout holds its value.
- Reading a stray non-header byte while pkt_cnt == 0 is legal. dout shows the byte and pkt_cnt stays 0.
- Reset mid-packet (rst or soft_reset): all packet state is discarded. The next read must begin at a new header.
- No tri-state on dout. No combinational path from din to dout.

Decomposition:
- Shared package router_pkg holds:
  - DATA_W, ROUTER_DEPTH, PTR_W.
  - Header field positions: LEN_MSB=7, LEN_LSB=2, ADDR_MSB=1, ADDR_LSB=0.
  - The soft-reset time-out constant (30) used by the synchronizer.
- One sub-module is natural: router_fifo_mem, a simple dual-port register array (DEPTH x DATA_W+1, sync write, async read). Pointer, flag and pkt_cnt logic stay in router_fifo.

Test Plan:
- rst low mid-run -> immediately empty=1, full=0, dout=0. After release, a read attempt is ignored (rd_ptr unchanged).
- Write header 8'h0D (len 3, addr 1) with lfd_state=1, then 3 payload bytes and 1 parity byte; read 5 times -> dout = 0D, p0, p1, p2, parity, each one cycle after its rd_en. Next idle cycle -> dout=0, empty=1.
- Write 16 bytes, no reads -> full=1 after the 16th write. A 17th write is ignored: reading 16 bytes returns the first 16 in order, then empty=1.
- Full FIFO with wr_en=1 and rd_en=1 in the same cycle -> only the read occurs; full drops to 0 and count goes 16->15.
- Half-full FIFO with simultaneous wr_en and rd_en for 20 cycles -> occupancy constant, pointers wrap past 15, data order preserved.
- soft_reset asserted during the 3rd payload read with wr_en=1 -> next cycle empty=1, dout=0, pkt_cnt=0. The concurrent write is lost.
